// File: rtl/alu_sequencer.sv
// Three-state controller that feeds an external 16-bit ALU from an internal 8x16
// register file and writes each result back, one instruction per three cycles.
module alu_sequencer #(
   parameter int DATA_W  = 16,
   parameter bit R0_ZERO = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [15:0]       instr,
   output logic [DATA_W-1:0] alu_in0,
   output logic [DATA_W-1:0] alu_in1,
   output logic [2:0]        alu_op,
   input  logic [DATA_W-1:0] alu_out,
   output logic              done,
   output logic [2:0]        done_rd,
   output logic              zero,
   input  logic [2:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t            state;
   logic [15:0]       instr_q;
   logic [DATA_W-1:0] result;
   logic [DATA_W-1:0] regs [0:7];
   logic [2:0]        op_q;
   logic [2:0]        rd_q;
   logic [DATA_W-1:0] imm_q;

   function automatic logic [DATA_W-1:0] read_reg(input logic [2:0] addr);
      if (R0_ZERO && (addr == 3'd0)) begin
         return {DATA_W{1'b0}};
      end
      return regs[addr];
   endfunction

   assign op_q        = instr_q[15:13];
   assign rd_q        = instr_q[12:10];
   assign imm_q       = {{(DATA_W-10){1'b0}}, instr_q[9:0]};
   assign instr_ready = (state == IDLE) && !rst;
   assign dbg_data    = read_reg(dbg_addr);

   // Sequencer FSM, register file and all registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         instr_q <= 16'h0000;
         result  <= {DATA_W{1'b0}};
         done    <= 1'b0;
         done_rd <= 3'd0;
         zero    <= 1'b0;
         alu_in0 <= {DATA_W{1'b0}};
         alu_in1 <= {DATA_W{1'b0}};
         alu_op  <= 3'd0;
         for (int i = 0; i < 8; i++) begin
            regs[i] <= {DATA_W{1'b0}};
         end
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (instr_valid) begin
                  // Operands are registered at accept so they appear during EXEC;
                  // the previous write-back has already landed by this edge.
                  instr_q <= instr;
                  alu_in0 <= read_reg(instr[9:7]);
                  alu_in1 <= read_reg(instr[6:4]);
                  alu_op  <= instr[15:13];
                  state   <= EXEC;
               end
            end
            EXEC: begin
               result  <= (op_q == 3'b111) ? imm_q : alu_out;
               alu_in0 <= {DATA_W{1'b0}};
               alu_in1 <= {DATA_W{1'b0}};
               alu_op  <= 3'd0;
               state   <= WB;
            end
            WB: begin
               if (!(R0_ZERO && (rd_q == 3'd0))) begin
                  regs[rd_q] <= result;
               end
               zero    <= (result == {DATA_W{1'b0}});
               done    <= 1'b1;
               done_rd <= rd_q;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios plus randomized
// instructions compared against an instruction-level register-file model.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [15:0] alu_in0;
   logic [15:0] alu_in1;
   logic [2:0]  alu_op;
   logic [15:0] alu_out;
   logic        done;
   logic [2:0]  done_rd;
   logic        zero;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;

   int checks = 0;
   int failures = 0;

   logic [15:0] mreg [0:7];
   logic        mzero;

   alu_sequencer #(.DATA_W(16), .R0_ZERO(1'b1)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_op(alu_op),
      .alu_out(alu_out), .done(done), .done_rd(done_rd), .zero(zero),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   // External ALU stand-in
   always_comb begin
      case (alu_op)
         3'd0: alu_out = alu_in0 + alu_in1;
         3'd1: alu_out = alu_in0 - alu_in1;
         3'd2: alu_out = ~alu_in0;
         3'd3: alu_out = alu_in0 & alu_in1;
         3'd4: alu_out = alu_in0 | alu_in1;
         3'd5: alu_out = alu_in0 ^ alu_in1;
         3'd6: alu_out = ~(alu_in0 ^ alu_in1);
         default: alu_out = 16'h0000;
      endcase
   end

   function automatic logic [15:0] mread(input logic [2:0] a);
      return (a == 3'd0) ? 16'h0000 : mreg[a];
   endfunction

   function automatic logic [15:0] mresult(input logic [15:0] w);
      logic [15:0] a;
      logic [15:0] b;
      a = mread(w[9:7]);
      b = mread(w[6:4]);
      case (w[15:13])
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return ~a;
         3'd3: return a & b;
         3'd4: return a | b;
         3'd5: return a ^ b;
         3'd6: return ~(a ^ b);
         default: return {6'b000000, w[9:0]};
      endcase
   endfunction

   task automatic mstep(input logic [15:0] w);
      logic [15:0] r;
      r = mresult(w);
      if (w[12:10] != 3'd0) mreg[w[12:10]] = r;
      mzero = (r == 16'h0000);
   endtask

   task automatic mreset();
      for (int i = 0; i < 8; i++) mreg[i] = 16'h0000;
      mzero = 1'b0;
   endtask

   // Issues one instruction from an IDLE negedge and returns what was observed;
   // returns at the negedge of the cycle in which done should be high.
   task automatic issue(input logic [15:0] w, output logic [15:0] o0, output logic [15:0] o1,
                        output logic [2:0] op, output logic rdy_exec, output logic dn_wb,
                        output logic dn, output logic [2:0] drd, output logic z);
      instr = w;
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      instr = 16'($urandom);
      o0 = alu_in0; o1 = alu_in1; op = alu_op; rdy_exec = instr_ready;
      @(negedge clk);
      dn_wb = done;
      @(negedge clk);
      dn = done; drd = done_rd; z = zero;
   endtask

   task automatic test_reset();
      rst = 1'b1; instr_valid = 1'b1; instr = 16'hE405; dbg_addr = 3'd0;
      repeat (2) @(negedge clk);
      checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", instr_ready); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
      checks++; if (zero !== 1'b0) begin failures++; $display("FAIL rst_zero got=%b exp=0", zero); end
      checks++; if (alu_op !== 3'd0) begin failures++; $display("FAIL rst_alu_op got=%0d exp=0", alu_op); end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         checks++; if (dbg_data !== 16'h0000) begin failures++; $display("FAIL rst_dbg r%0d got=%h exp=0000", i, dbg_data); end
      end
      @(negedge clk);
      instr_valid = 1'b0;
      rst = 1'b0;
      #1;
      checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", instr_ready); end
      checks++; if (alu_op !== 3'd0) begin failures++; $display("FAIL rst_release_op got=%0d exp=0", alu_op); end
      @(negedge clk);
      checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL idle_hold_ready got=%b exp=1", instr_ready); end
      mreset();
   endtask

   task automatic test_load_add();
      logic [15:0] o0, o1; logic [2:0] op, drd; logic rdy, dnw, dn, z;
      issue(16'hE405, o0, o1, op, rdy, dnw, dn, drd, z); mstep(16'hE405);
      issue(16'hE803, o0, o1, op, rdy, dnw, dn, drd, z); mstep(16'hE803);
      issue(16'h0CA0, o0, o1, op, rdy, dnw, dn, drd, z); mstep(16'h0CA0);
      checks++; if (o0 !== 16'h0005) begin failures++; $display("FAIL add_in0 got=%h exp=0005", o0); end
      checks++; if (o1 !== 16'h0003) begin failures++; $display("FAIL add_in1 got=%h exp=0003", o1); end
      checks++; if (op !== 3'd0) begin failures++; $display("FAIL add_op got=%0d exp=0", op); end
      checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL add_ready_exec got=%b exp=0", rdy); end
      checks++; if (dnw !== 1'b0) begin failures++; $display("FAIL add_done_early got=%b exp=0", dnw); end
      checks++; if (dn !== 1'b1) begin failures++; $display("FAIL add_done got=%b exp=1", dn); end
      checks++; if (drd !== 3'd3) begin failures++; $display("FAIL add_done_rd got=%0d exp=3", drd); end
      checks++; if (z !== 1'b0) begin failures++; $display("FAIL add_zero got=%b exp=0", z); end
      dbg_addr = 3'd3; #1;
      checks++; if (dbg_data !== 16'h0008) begin failures++; $display("FAIL add_r3 got=%h exp=0008", dbg_data); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL add_done_pulse got=%b exp=0", done); end
   endtask

   task automatic test_wrap_zero();
      logic [15:0] o0, o1; logic [2:0] op, drd; logic rdy, dnw, dn, z;
      issue(16'h3110, o0, o1, op, rdy, dnw, dn, drd, z); mstep(16'h3110);
      dbg_addr = 3'd4; #1;
      checks++; if (dbg_data !== 16'hFFFE) begin failures++; $display("FAIL sub_r4 got=%h exp=fffe", dbg_data); end
      checks++; if (z !== 1'b0) begin failures++; $display("FAIL sub_zero got=%b exp=0", z); end
      issue(16'hB490, o0, o1, op, rdy, dnw, dn, drd, z); mstep(16'hB490);
      dbg_addr = 3'd5; #1;
      checks++; if (dbg_data !== 16'h0000) begin failures++; $display("FAIL xor_r5 got=%h exp=0000", dbg_data); end
      checks++; if (z !== 1'b1) begin failures++; $display("FAIL xor_zero got=%b exp=1", z); end
      checks++; if (drd !== 3'd5) begin failures++; $display("FAIL xor_done_rd got=%0d exp=5", drd); end
      @(negedge clk);
      checks++; if (zero !== 1'b1) begin failures++; $display("FAIL zero_hold got=%b exp=1", zero); end
   endtask

   task automatic test_r0();
      logic [15:0] o0, o1; logic [2:0] op, drd; logic rdy, dnw, dn, z;
      issue(16'hE3FF, o0, o1, op, rdy, dnw, dn, drd, z); mstep(16'hE3FF);
      checks++; if (op !== 3'd7) begin failures++; $display("FAIL ldi_op got=%0d exp=7", op); end
      checks++; if (dn !== 1'b1) begin failures++; $display("FAIL r0_done got=%b exp=1", dn); end
      checks++; if (drd !== 3'd0) begin failures++; $display("FAIL r0_done_rd got=%0d exp=0", drd); end
      checks++; if (z !== 1'b0) begin failures++; $display("FAIL r0_zero got=%b exp=0", z); end
      dbg_addr = 3'd0; #1;
      checks++; if (dbg_data !== 16'h0000) begin failures++; $display("FAIL r0_dbg got=%h exp=0000", dbg_data); end
   endtask

   task automatic test_back_to_back();
      int cnt;
      instr = 16'hF80A; instr_valid = 1'b1;
      @(posedge clk);
      mstep(16'hF80A);
      @(negedge clk);
      instr = 16'h1F60;
      cnt = 1;
      while (!instr_ready && cnt < 8) begin
         checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_busy got=%b exp=0 cycle=%0d", done, cnt); end
         @(negedge clk);
         cnt++;
      end
      checks++; if (cnt !== 3) begin failures++; $display("FAIL b2b_accept_gap got=%0d exp=3", cnt); end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done_first got=%b exp=1", done); end
      @(posedge clk);
      mstep(16'h1F60);
      @(negedge clk);
      instr_valid = 1'b0;
      checks++; if (alu_in0 !== 16'h000A || alu_in1 !== 16'h000A) begin failures++; $display("FAIL b2b_operands got=%h,%h exp=000a,000a", alu_in0, alu_in1); end
      repeat (2) @(negedge clk);
      checks++; if (done !== 1'b1 || done_rd !== 3'd7) begin failures++; $display("FAIL b2b_done got=%b rd=%0d exp=1 rd=7", done, done_rd); end
      dbg_addr = 3'd7; #1;
      checks++; if (dbg_data !== 16'h0014) begin failures++; $display("FAIL b2b_r7 got=%h exp=0014", dbg_data); end
   endtask

   task automatic test_reset_midop();
      logic [15:0] o0, o1; logic [2:0] op, drd; logic rdy, dnw, dn, z;
      logic seen_done;
      instr = 16'h0CA0; instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      rst = 1'b1;
      mreset();
      #1;
      checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL midop_ready got=%b exp=0", instr_ready); end
      seen_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      rst = 1'b0;
      #1;
      checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL midop_done got=%b exp=0", seen_done); end
      checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL midop_release_ready got=%b exp=1", instr_ready); end
      dbg_addr = 3'd3; #1;
      checks++; if (dbg_data !== 16'h0000) begin failures++; $display("FAIL midop_r3 got=%h exp=0000", dbg_data); end
      @(negedge clk);
      issue(16'hE405, o0, o1, op, rdy, dnw, dn, drd, z); mstep(16'hE405);
      dbg_addr = 3'd1; #1;
      checks++; if (dn !== 1'b1 || drd !== 3'd1 || dbg_data !== 16'h0005) begin failures++; $display("FAIL midop_fresh_ldi got=done%b rd%0d r1=%h exp=done1 rd1 r1=0005", dn, drd, dbg_data); end
   endtask

   task automatic test_random();
      logic [15:0] o0, o1, w, e0, e1; logic [2:0] op, drd; logic rdy, dnw, dn, z;
      for (int i = 0; i < 48; i++) begin
         if (i < 8) w = {3'b111, 3'(i), 10'($urandom)};
         else w = 16'($urandom);
         e0 = mread(w[9:7]);
         e1 = mread(w[6:4]);
         issue(w, o0, o1, op, rdy, dnw, dn, drd, z);
         mstep(w);
         checks++; if (o0 !== e0 || o1 !== e1 || op !== w[15:13]) begin failures++; $display("FAIL rnd_exec w=%h got=%h,%h,%0d exp=%h,%h,%0d", w, o0, o1, op, e0, e1, w[15:13]); end
         checks++; if (dn !== 1'b1 || drd !== w[12:10] || z !== mzero) begin failures++; $display("FAIL rnd_done w=%h got=done%b rd%0d z%b exp=done1 rd%0d z%b", w, dn, drd, z, w[12:10], mzero); end
         dbg_addr = w[12:10]; #1;
         checks++; if (dbg_data !== mread(w[12:10])) begin failures++; $display("FAIL rnd_dbg w=%h got=%h exp=%h", w, dbg_data, mread(w[12:10])); end
      end
   endtask

   initial begin
      rst = 1'b1; instr_valid = 1'b0; instr = 16'h0000; dbg_addr = 3'd0;
      mreset();
      @(negedge clk);
      test_reset();
      test_load_add();
      test_wrap_zero();
      test_r0();
      test_back_to_back();
      @(negedge clk);
      test_reset_midop();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
